// File: rtl/slave_serial_port_pkg.sv
// Shared definitions for the slave serial port: FSM state encoding,
// bus mode constants and a small sizing helper.
// Bit order: every serial field (address, write data, read data) is LSB first.
package slave_serial_port_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      WRITE,
      RREQ,
      RWAIT,
      RDATA
   } state_t;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/slave_serial_port_if.sv
// Bus-side serial link between the bus fabric (master side) and one slave port.
interface slave_serial_port_if;

   logic swdata;
   logic smode;
   logic mvalid;
   logic srdata;
   logic svalid;
   logic sready;

   modport master (
      output swdata, smode, mvalid,
      input  srdata, svalid, sready
   );

   modport slave (
      input  swdata, smode, mvalid,
      output srdata, svalid, sready
   );

endinterface

// File: rtl/slave_serial_port_serial_shift_reg.sv
// Parallel-load / LSB-first shift register. Shifting moves data toward bit 0
// and inserts shift_in at the MSB, so after WIDTH shifts the first bit
// received sits in bit 0.
module serial_shift_reg
   import slave_serial_port_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   input  logic             shift_in,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] shifted;

   if (WIDTH == 1) begin : g_one
      assign shifted = shift_in;
   end else begin : g_multi
      assign shifted = {shift_in, data[WIDTH-1:1]};
   end

   // Register: load has priority over shift; holds otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= shifted;
      end
   end

endmodule

// File: rtl/slave_serial_port.sv
// Slave-side serial protocol engine: deserialises address/write data from the
// bus, issues single-cycle memory strobes, and serialises read data back.
// Optional macro SLAVE_ADDR_RANGE_CHECK_EN suppresses memory strobes for
// addresses >= MEM_SIZE (reads then return zeros) with unchanged bus timing.
module slave_serial_port
   import slave_serial_port_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned MEM_SIZE     = 4096,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   slave_serial_port_if.slave    bus,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned CW = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, READ_LATENCY) + 1);

`ifdef SLAVE_ADDR_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   state_t          state, next_state;
   logic            mode, mode_next;
   logic [CW-1:0]   cnt, cnt_next;

   logic            addr_shift;
   logic            wdata_shift;
   logic            rd_load;
   logic            rd_shift;
   logic [DATA_WIDTH:0] rd_word;

   logic            in_range;
   logic            addr_ok;

   assign in_range = (32'(mem_addr) < MEM_SIZE);
   assign addr_ok  = !RANGE_CHECK || in_range;

   // Address and write-data shift registers drive the memory bus directly;
   // they only shift while their field is being received, so they hold
   // their last values between transactions.
   serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
      .clk       (clk),
      .rstn      (rstn),
      .load      (1'b0),
      .load_data ('0),
      .shift     (addr_shift),
      .shift_in  (bus.swdata),
      .data      (mem_addr)
   );

   serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
      .clk       (clk),
      .rstn      (rstn),
      .load      (1'b0),
      .load_data ('0),
      .shift     (wdata_shift),
      .shift_in  (bus.swdata),
      .data      (mem_wdata)
   );

   // Read data is loaded with a marker '1' above the MSB; shifting in zeros,
   // the marker reaching bit 1 identifies the last data bit, so RDATA needs
   // no separate counter.
   serial_shift_reg #(.WIDTH(DATA_WIDTH + 1)) u_rdata_sr (
      .clk       (clk),
      .rstn      (rstn),
      .load      (rd_load),
      .load_data ({1'b1, (addr_ok ? mem_rdata : {DATA_WIDTH{1'b0}})}),
      .shift     (rd_shift),
      .shift_in  (1'b0),
      .data      (rd_word)
   );

   // State, captured mode and shared bit/cycle counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         mode  <= MODE_READ;
         cnt   <= '0;
      end else begin
         state <= next_state;
         mode  <= mode_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      next_state  = state;
      mode_next   = mode;
      cnt_next    = cnt;
      addr_shift  = 1'b0;
      wdata_shift = 1'b0;
      rd_load     = 1'b0;
      rd_shift    = 1'b0;
      bus.sready  = 1'b0;
      bus.svalid  = 1'b0;
      bus.srdata  = 1'b0;
      mem_wen     = 1'b0;
      mem_ren     = 1'b0;

      case (state)
         IDLE: begin
            bus.sready = 1'b1;
            if (bus.mvalid) begin
               addr_shift = 1'b1;
               mode_next  = bus.smode;
               if (ADDR_WIDTH == 1) begin
                  cnt_next   = '0;
                  next_state = (bus.smode == MODE_WRITE) ? WDATA : RREQ;
               end else begin
                  cnt_next   = CW'(1);
                  next_state = ADDR;
               end
            end
         end
         ADDR: begin
            if (bus.mvalid) begin
               addr_shift = 1'b1;
               if (cnt == CW'(ADDR_WIDTH - 1)) begin
                  cnt_next   = '0;
                  next_state = (mode == MODE_WRITE) ? WDATA : RREQ;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
         WDATA: begin
            if (bus.mvalid) begin
               wdata_shift = 1'b1;
               if (cnt == CW'(DATA_WIDTH - 1)) begin
                  cnt_next   = '0;
                  next_state = WRITE;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
         WRITE: begin
            mem_wen    = addr_ok;
            next_state = IDLE;
         end
         RREQ: begin
            mem_ren    = addr_ok;
            cnt_next   = '0;
            next_state = RWAIT;
         end
         RWAIT: begin
            if (cnt == CW'(READ_LATENCY - 1)) begin
               rd_load    = 1'b1;
               cnt_next   = '0;
               next_state = RDATA;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         RDATA: begin
            bus.svalid = 1'b1;
            bus.srdata = rd_word[0];
            rd_shift   = 1'b1;
            if (rd_word[DATA_WIDTH:1] == DATA_WIDTH'(1)) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: doc/slave_serial_port.md
Name: slave_serial_port

Overview:
- Bus-side protocol engine for a slave; sits directly downstream of the 2-master/3-slave serial bus and upstream of a BRAM.
- Deserialises the 1-bit address/data stream and mode from the bus and issues single-cycle parallel write/read strobes to the memory.
- Serialises read data back onto the bus with a valid strobe.
- Drives sready so the bus only routes a new transaction to it when idle.

Parameters:
ADDR_WIDTH, 12, slave-local address bits received per transaction
DATA_WIDTH, 8, data bits per transfer
MEM_SIZE, 4096, number of implemented words; used only by the optional range check
READ_LATENCY, 1, cycles from mem_ren to valid mem_rdata (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous, active-low reset
swdata  in  1  serial address then write-data bit from bus
smode  in  1  0 read, 1 write; sampled with the first address bit
mvalid  in  1  swdata bit valid this cycle
srdata  out  1  serial read-data bit to bus
svalid  out  1  srdata valid this cycle
sready  out  1  port idle, may accept a new transaction
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_wen  out  1  one-cycle write strobe
mem_ren  out  1  one-cycle read strobe
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, rstn=0): state IDLE, counters and shift registers 0. Outputs: sready=1; srdata, svalid, mem_wen, mem_ren = 0; mem_addr, mem_wdata = 0.
- Reset mid-transaction aborts immediately. No strobe is issued for the partial transaction.
- All serial fields are LSB first. A bit is consumed only in a cycle with mvalid=1. Gaps (mvalid=0) are allowed between bits and do not advance counters.
- States: IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA.
- IDLE:
  - sready=1.
  - mvalid=1: capture addr bit0 and smode; go to ADDR.
  - If ADDR_WIDTH==1, skip ADDR and go straight to WDATA/RREQ per mode.
- ADDR: collect bits 1..ADDR_WIDTH-1. After the last bit: write -> WDATA, read -> RREQ.
- WDATA: collect DATA_WIDTH bits. After the last bit -> WRITE.
- WRITE:
  - mem_wen=1 for exactly one cycle, with mem_addr/mem_wdata stable.
  - Then -> IDLE.
- RREQ:
  - mem_ren=1 for one cycle, with mem_addr stable.
  - Then -> RWAIT.
- RWAIT:
  - Lasts READ_LATENCY cycles.
  - mem_rdata is registered in the last RWAIT cycle.
  - Then -> RDATA.
- RDATA:
  - svalid=1 for DATA_WIDTH consecutive cycles, no gaps.
  - srdata = captured bit i in the i-th cycle.
  - Then -> IDLE.
- mvalid and swdata are ignored in WRITE/RREQ/RWAIT/RDATA. sready=0 in every state except IDLE.
- Timing, last write-data bit in cycle T:
  - mem_wen at T+1.
  - sready=1 at T+2.
- Timing, last address bit in cycle T (L = READ_LATENCY):
  - mem_ren at T+1.
  - svalid at T+2+L through T+1+L+DATA_WIDTH.
  - sready=1 at T+2+L+DATA_WIDTH.
- Back-to-back: mvalid=1 in the first IDLE cycle starts the next transaction with no lost bit.
- Outputs mem_addr and mem_wdata hold their last values between transactions.

Optional Feature:
- Macro SLAVE_ADDR_RANGE_CHECK_EN.
- Defined: a received address >= MEM_SIZE is out of range.
  - Write: WRITE state still lasts one cycle, but mem_wen stays 0.
  - Read: mem_ren stays 0. RWAIT still lasts READ_LATENCY cycles. Returned data is all zeros.
  - Bus-side timing is identical to the in-range case.
- Undefined: no check. Any address is passed to memory unchanged.

Decomposition:
- Shared package: state encoding enum, protocol constants (MODE_READ=0, MODE_WRITE=1), bit-order note.
- One natural sub-module: serial_shift_reg (width parameter; load, shift-in and shift-out). It is instantiated for address, write data and read data.

Test Plan:
- Write, ADDR_WIDTH=12, DATA_WIDTH=8: smode=1, addr 0x123 then data 0xA5 serially with continuous mvalid -> mem_wen pulse one cycle after the last bit, mem_addr=0x123, mem_wdata=0xA5; sready back 2 cycles after the last bit.
- Read, READ_LATENCY=1: addr 0x123, model returns 0xA5 -> mem_ren at T+1; svalid for cycles T+3..T+10; srdata sequence 1,0,1,0,0,1,0,1.
- Gapped bits: write addr 0x0F0, data 0x3C with mvalid low every other cycle -> same captured values; exactly one mem_wen.
- Back-to-back: write 0x55@0x001, then mvalid high in the first sready cycle for a read @0x001 -> no dropped bit; read returns 0x55.
- Reset mid-operation: rstn low after 6 address bits -> all outputs at reset values immediately; no mem_wen/mem_ren; the next full write works.
- SLAVE_ADDR_RANGE_CHECK_EN with MEM_SIZE=2048:
  - Write to 0x900: no mem_wen.
  - Read from 0x900: srdata all zeros with normal svalid timing.
  - 0x7FF: normal operation.
